// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator; VGA_FRAME_CNT_EN enables the frame_count counter
module vga_timing #(
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int SYNC_DELAY = 1
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  output logic [9:0]  VGA_X,
  output logic [9:0]  VGA_Y,
  output logic        visible,
  output logic        line_start,
  output logic        frame_start,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_BEG  = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS_END  = 10'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0] V_VIS_BEG  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_VIS_END  = 10'(V_SYNC + V_BACK + V_VISIBLE);

  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       h_wrap;
  logic       frame_wrap;
  logic       hs_raw;
  logic       vs_raw;

  always_comb begin
    h_wrap = (VGA_X == H_LAST);
    h_nxt  = h_wrap ? 10'd0 : VGA_X + 10'd1;
    v_nxt  = VGA_Y;
    if (h_wrap) begin
      v_nxt = (VGA_Y == V_LAST) ? 10'd0 : VGA_Y + 10'd1;
    end
    frame_wrap = (h_nxt == 10'd0) && (v_nxt == 10'd0);
  end

  // Decodes are taken from the next-state counters so they align with VGA_X/VGA_Y.
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      VGA_X       <= 10'd0;
      VGA_Y       <= 10'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      visible     <= 1'b0;
      hs_raw      <= 1'b1;
      vs_raw      <= 1'b1;
    end else begin
      VGA_X       <= h_nxt;
      VGA_Y       <= v_nxt;
      line_start  <= (h_nxt == 10'd0);
      frame_start <= frame_wrap;
      visible     <= (h_nxt >= H_VIS_BEG) && (h_nxt < H_VIS_END) &&
                     (v_nxt >= V_VIS_BEG) && (v_nxt < V_VIS_END);
      hs_raw      <= (h_nxt >= H_SYNC_END);
      vs_raw      <= (v_nxt >= V_SYNC_END);
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign VGA_HS      = hs_raw;
      assign VGA_VS      = vs_raw;
      assign VGA_BLANK_N = visible;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe;
      logic [SYNC_DELAY-1:0] vs_pipe;
      logic [SYNC_DELAY-1:0] bn_pipe;

      // Delay matches the renderer's registered RGB path.
      always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
          bn_pipe <= '0;
        end else begin
          hs_pipe[0] <= hs_raw;
          vs_pipe[0] <= vs_raw;
          bn_pipe[0] <= visible;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
            bn_pipe[i] <= bn_pipe[i-1];
          end
        end
      end

      assign VGA_HS      = hs_pipe[SYNC_DELAY-1];
      assign VGA_VS      = vs_pipe[SYNC_DELAY-1];
      assign VGA_BLANK_N = bn_pipe[SYNC_DELAY-1];
    end
  endgenerate

  assign VGA_SYNC_N = 1'b0;

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      frame_count <= 16'd0;
    end else if (frame_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - scoreboard bench for vga_timing with random reset episodes
module tb_vga_timing;

  localparam int HS_W = 8;
  localparam int HB_W = 5;
  localparam int HV_W = 20;
  localparam int HF_W = 4;
  localparam int VS_W = 2;
  localparam int VB_W = 3;
  localparam int VV_W = 6;
  localparam int VF_W = 2;
  localparam int DLY  = 2;
  localparam int HT    = HS_W + HB_W + HV_W + HF_W;
  localparam int VT    = VS_W + VB_W + VV_W + VF_W;
  localparam int FRAME = HT * VT;

  logic        VGA_CLK = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  VGA_X;
  logic [9:0]  VGA_Y;
  logic        visible;
  logic        line_start;
  logic        frame_start;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic        VGA_SYNC_N;
  logic [15:0] frame_count;

  vga_timing #(
    .H_SYNC(HS_W), .H_BACK(HB_W), .H_VISIBLE(HV_W), .H_FRONT(HF_W),
    .V_SYNC(VS_W), .V_BACK(VB_W), .V_VISIBLE(VV_W), .V_FRONT(VF_W),
    .SYNC_DELAY(DLY)
  ) dut (
    .VGA_CLK(VGA_CLK), .reset(reset), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
    .visible(visible), .line_start(line_start), .frame_start(frame_start),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .frame_count(frame_count)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  typedef struct {
    int x, y, vis, ls, fs, hs, vs, bn, fc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   t = 0;

  // t = rising edges since reset release; raster position is t mod frame length.
  function automatic void raw_decode(input int tt, output int h, output int v, output int vis);
    int p, x, y;
    if (tt <= 0) begin
      h = 1; v = 1; vis = 0;
    end else begin
      p = tt % FRAME; x = p % HT; y = p / HT;
      h   = (x < HS_W) ? 0 : 1;
      v   = (y < VS_W) ? 0 : 1;
      vis = (x >= HS_W + HB_W && x < HS_W + HB_W + HV_W &&
             y >= VS_W + VB_W && y < VS_W + VB_W + VV_W) ? 1 : 0;
    end
  endfunction

  function automatic exp_t model(input int tt);
    exp_t e;
    int p, h, v, vis;
    p   = tt % FRAME;
    e.x = p % HT;
    e.y = p / HT;
    e.ls = (tt > 0 && e.x == 0) ? 1 : 0;
    e.fs = (tt > 0 && p == 0) ? 1 : 0;
    raw_decode(tt, h, v, vis);
    e.vis = vis;
    raw_decode(tt - DLY, h, v, vis);
    e.hs = h; e.vs = v; e.bn = vis;
`ifdef VGA_FRAME_CNT_EN
    e.fc = (tt / FRAME) % 65536;
`else
    e.fc = 0;
`endif
    return e;
  endfunction

  always @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      if (!VGA_CLK || $time == 0 || 1) begin
        exp_q.delete();
        t = 0;
        exp_q.push_back(model(0));
      end
    end else begin
      t = t + 1;
      exp_q.push_back(model(t));
    end
  end

  task automatic chk(input string name, input int act, input int req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, req);
    end
  endtask

  always @(negedge VGA_CLK) begin
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty t=%0d actual=0 required=1", t);
    end else begin
      e = exp_q.pop_front();
      chk("VGA_X", int'(VGA_X), e.x);
      chk("VGA_Y", int'(VGA_Y), e.y);
      chk("visible", int'(visible), e.vis);
      chk("line_start", int'(line_start), e.ls);
      chk("frame_start", int'(frame_start), e.fs);
      chk("VGA_HS", int'(VGA_HS), e.hs);
      chk("VGA_VS", int'(VGA_VS), e.vs);
      chk("VGA_BLANK_N", int'(VGA_BLANK_N), e.bn);
      chk("VGA_SYNC_N", int'(VGA_SYNC_N), 0);
      chk("frame_count", int'(frame_count), e.fc);
    end
  end

  initial begin
    int n;
    reset = 1'b0;
    repeat (10) @(posedge VGA_CLK);
    @(negedge VGA_CLK);
    #2 reset = 1'b1;
    for (int ep = 0; ep < 6; ep++) begin
      n = (ep == 0) ? 3 * FRAME + 50 : int'($urandom_range(50, 2 * FRAME));
      repeat (n) @(posedge VGA_CLK);
      #2 reset = 1'b0;
      repeat ($urandom_range(1, 4)) @(posedge VGA_CLK);
      @(negedge VGA_CLK);
      #2 reset = 1'b1;
    end
    repeat (FRAME + 20) @(posedge VGA_CLK);
    @(negedge VGA_CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25.175 MHz pixel clock.
- Raw VGA_X/VGA_Y sweep the full frame, with sync and back porch counted from 0.
  - Visible area is X 144..783, Y 35..514.
  - The screen renderer subtracts these offsets to get pixel coordinates.
- Drives HS/VS/BLANK_N/SYNC_N to the DAC and delays them to line up with the renderer's registered RGB.

Parameters:
- H_SYNC, 96, horizontal sync pulse width in clocks
- H_BACK, 48, horizontal back porch
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- SYNC_DELAY, 1, clocks of delay on HS/VS/BLANK_N relative to VGA_X/VGA_Y (legal range 0..4)

Ports:
- VGA_CLK  in  1  pixel clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- VGA_X  out  10  horizontal counter, 0..H_TOTAL-1
- VGA_Y  out  10  vertical counter, 0..V_TOTAL-1
- visible  out  1  high when VGA_X/VGA_Y is in the visible area (undelayed)
- line_start  out  1  one-clock pulse when VGA_X==0
- frame_start  out  1  one-clock pulse when VGA_X==0 and VGA_Y==0
- VGA_HS  out  1  horizontal sync, active low, delayed SYNC_DELAY
- VGA_VS  out  1  vertical sync, active low, delayed SYNC_DELAY
- VGA_BLANK_N  out  1  low outside the visible area, delayed SYNC_DELAY
- VGA_SYNC_N  out  1  constant 0 (no sync-on-green)
- frame_count  out  16  completed frames (see Optional Feature)

Behaviour:
- Totals:
  - H_TOTAL = sum of the H_* parameters = 800.
  - V_TOTAL = sum of the V_* parameters = 525.
- Reset asserted (reset==0), async, all outputs at these values:
  - VGA_X=0, VGA_Y=0.
  - visible=0, line_start=0, frame_start=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, frame_count=0.
  - All delay-pipeline stages hold the inactive values HS=1, VS=1, BLANK_N=0.
- First rising edge after release: VGA_X becomes 1.
  - No frame_start or line_start pulse for the initial (0,0) state.
- Horizontal counter: increments every clock; at H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only on the horizontal wrap; at V_TOTAL-1 with the horizontal wrap it goes to 0.
- All pulses and decodes below are registered from the next-state counter values, so they are cycle-aligned with VGA_X/VGA_Y (zero skew):
  - line_start=1 exactly in the cycle VGA_X==0.
  - frame_start=1 exactly in the cycle VGA_X==0 and VGA_Y==0.
  - visible=1 iff H_SYNC+H_BACK <= X < H_SYNC+H_BACK+H_VISIBLE and V_SYNC+V_BACK <= Y < V_SYNC+V_BACK+V_VISIBLE.
- Undelayed sync decodes:
  - hs_raw=0 iff X < H_SYNC.
  - vs_raw=0 iff Y < V_SYNC (whole lines, including their horizontal blanking).
- Delay pipeline:
  - hs_raw, vs_raw and visible pass through a SYNC_DELAY-stage shift register to form VGA_HS, VGA_VS and VGA_BLANK_N.
  - SYNC_DELAY=0 means the registered decodes drive the outputs directly.
- Mid-frame reset forces the reset values immediately (async); the counters restart from (0,0). No partial-line recovery is required.
- No other inputs; the block free-runs. Width rule: 10 bits cover H_TOTAL ≤ 1024.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined: frame_count increments by 1 in the same cycle frame_start rises, i.e. on each frame wrap, and wraps 65535→0. It resets to 0.
- Undefined: frame_count is tied to 16'd0 and no counter logic is synthesised. The port list is identical either way.

Test Plan:
- Reset held 10 clocks, then released → during reset X=0, Y=0, HS=1, VS=1, BLANK_N=0. One clock after release X=1; no frame_start before the X=0/Y=0 wrap after 420000 clocks.
- Run one line → X reaches 799, then 0 with Y=1 and line_start=1 for one clock. VGA_HS (SYNC_DELAY=1) is low for exactly 96 clocks, falling 1 clock after X wraps to 0.
- Run 2 frames → exactly 420000 clocks between frame_start pulses. VGA_VS is low for 1600 clocks (lines 0..1).
- Check the visible window → visible=1 first at (144,35) and last at (783,514). VGA_BLANK_N follows visible delayed 1 clock; BLANK_N high count per frame is 307200.
- Assert reset at X=400, Y=200 → outputs go to reset values within the same cycle (async). After release, counting restarts from (1,0).
- With VGA_FRAME_CNT_EN defined, run 3 full frames after reset → frame_count steps 0→1→2→3, each increment coinciding with frame_start. Undefined → frame_count stays 0.
